ssp_cfg_sync_ctrl: RTL and testbench

Sequences configuration transfers from the AHB register side into the AHB_SYNC req/ack crossing. It keeps shadow copies of DADR/CADR/DLEN/DBIT and launches a 4-phase req/ack transfer whenever the shadow changes. Writes that arrive during a transfer are coalesced into a single follow-up transfer. A hung handshake is detected by a timeout and reported through a sticky error flag. It sits between the AHB slave register decode and the AHB_SYNC instance feeding the SSP/CRC core.

---
 rtl/ssp_cfg_pkg.sv | 13 +
 rtl/ssp_cfg_shadow.sv | 45 ++++
 rtl/ssp_cfg_sync_ctrl.sv | 141 ++++++++++++++
 tb/tb_ssp_cfg_sync_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ssp_cfg_pkg.sv
// Shared types and defaults for the SSP configuration sync controller.
package ssp_cfg_pkg;
  localparam int ADR_W_DEF   = 6;
  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    REL   = 2'd2,
    ABORT = 2'd3
  } cfg_state_e;
endpackage

// File: rtl/ssp_cfg_shadow.sv
// Shadow copies of DADR/CADR/DLEN/DBIT plus the "not yet transferred" flag.
module ssp_cfg_shadow
  import ssp_cfg_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEF
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             wr_dadr,
  input  logic             wr_cadr,
  input  logic             wr_ctrl,
  input  logic [ADR_W-1:0] wdata_adr,
  input  logic             wdata_dlen,
  input  logic             wdata_dbit,
  input  logic             launch,
  input  logic             retry,
  output logic [ADR_W-1:0] sh_dadr,
  output logic [ADR_W-1:0] sh_cadr,
  output logic             sh_dlen,
  output logic             sh_dbit,
  output logic             pending
);
  logic any_wr;
  assign any_wr = wr_dadr | wr_cadr | wr_ctrl;

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      sh_dadr <= '0;
      sh_cadr <= '0;
      sh_dlen <= 1'b0;
      sh_dbit <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (wr_dadr) sh_dadr <= wdata_adr;
      if (wr_cadr) sh_cadr <= wdata_adr;
      if (wr_ctrl) begin
        sh_dlen <= wdata_dlen;
        sh_dbit <= wdata_dbit;
      end
      // A write in the launch cycle wins over the clear, forcing a follow-up.
      if (any_wr || retry) pending <= 1'b1;
      else if (launch)     pending <= 1'b0;
    end
  end
endmodule

// File: rtl/ssp_cfg_sync_ctrl.sv
// 4-phase req/ack sequencer pushing shadowed config into the AHB_SYNC crossing.
module ssp_cfg_sync_ctrl
  import ssp_cfg_pkg::*;
#(
  parameter int ADR_W   = ADR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             wr_dadr,
  input  logic             wr_cadr,
  input  logic             wr_ctrl,
  input  logic [ADR_W-1:0] wdata_adr,
  input  logic             wdata_dlen,
  input  logic             wdata_dbit,
  input  logic             err_clr,
  output logic             req,
  input  logic             ack,
  output logic [ADR_W-1:0] DADR,
  output logic [ADR_W-1:0] CADR,
  output logic             DLEN,
  output logic             DBIT,
  output logic             busy,
  output logic             pending,
  output logic             done,
  output logic             err
);
  cfg_state_e       state_q, state_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q;
  logic             launch, to_abort, cnt_last;
  logic [ADR_W-1:0] sh_dadr, sh_cadr, x_dadr, x_cadr;
  logic             sh_dlen, sh_dbit, x_dlen, x_dbit;

  ssp_cfg_shadow #(.ADR_W(ADR_W)) u_shadow (
    .gclk       (HCLK),
    .grst_n     (HRESETn),
    .wr_dadr    (wr_dadr),
    .wr_cadr    (wr_cadr),
    .wr_ctrl    (wr_ctrl),
    .wdata_adr  (wdata_adr),
    .wdata_dlen (wdata_dlen),
    .wdata_dbit (wdata_dbit),
    .launch     (launch),
    .retry      (to_abort),
    .sh_dadr    (sh_dadr),
    .sh_cadr    (sh_cadr),
    .sh_dlen    (sh_dlen),
    .sh_dbit    (sh_dbit),
    .pending    (pending)
  );

  // Abort when the next increment would land on TIMEOUT-1.
  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 2));

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    launch   = 1'b0;
    to_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending) begin
          launch  = 1'b1;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = REL;
        end else if (cnt_last) begin
          to_abort = 1'b1;
          req_d    = 1'b0;
          state_d  = ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL: begin
        if (!ack) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_last) begin
          to_abort = 1'b1;
          state_d  = ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ABORT: begin
        if (!ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      x_dadr  <= '0;
      x_cadr  <= '0;
      x_dlen  <= 1'b0;
      x_dbit  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (to_abort)     err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
      if (launch) begin
        x_dadr <= sh_dadr;
        x_cadr <= sh_cadr;
        x_dlen <= sh_dlen;
        x_dbit <= sh_dbit;
      end
    end
  end

  assign req  = req_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = (state_q != IDLE);
  assign DADR = x_dadr;
  assign CADR = x_cadr;
  assign DLEN = x_dlen;
  assign DBIT = x_dbit;
endmodule

// File: tb/tb_ssp_cfg_sync_ctrl.sv
// Directed bench for ssp_cfg_sync_ctrl with a 3-cycle 4-phase ack responder.
module tb_ssp_cfg_sync_ctrl;
  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       wr_dadr, wr_cadr, wr_ctrl;
  logic [5:0] wdata_adr;
  logic       wdata_dlen, wdata_dbit, err_clr;
  logic       req, ack;
  logic [5:0] DADR, CADR;
  logic       DLEN, DBIT, busy, pending, done, err;

  logic ack_auto, ack_man;
  logic ack_m = 1'b0;
  int   dly = 0;
  int   total = 0, bad = 0;
  int   nreq = 0, ndone = 0, unstable = 0;
  int   b_req, b_done, n;
  logic req_prev = 1'b0;
  logic [13:0] x_prev = '0;
  logic [13:0] log_x [32];

  always #5 HCLK = ~HCLK;
  assign ack = ack_auto ? ack_m : ack_man;

  ssp_cfg_sync_ctrl #(.ADR_W(6), .TIMEOUT(8), .CNT_W(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .wr_dadr(wr_dadr), .wr_cadr(wr_cadr),
    .wr_ctrl(wr_ctrl), .wdata_adr(wdata_adr), .wdata_dlen(wdata_dlen),
    .wdata_dbit(wdata_dbit), .err_clr(err_clr), .req(req), .ack(ack),
    .DADR(DADR), .CADR(CADR), .DLEN(DLEN), .DBIT(DBIT), .busy(busy),
    .pending(pending), .done(done), .err(err)
  );

  // Responder follows req 3 negedges later; monitor logs payload at each req rise.
  always @(negedge HCLK) begin
    if (ack_m != req) begin
      if (dly == 2) begin ack_m = req; dly = 0; end
      else dly = dly + 1;
    end else dly = 0;
    if (req === 1'b1 && req_prev === 1'b1 && {DADR, CADR, DLEN, DBIT} !== x_prev)
      unstable = unstable + 1;
    if (req === 1'b1 && req_prev !== 1'b1) begin
      if (nreq < 32) log_x[nreq] = {DADR, CADR, DLEN, DBIT};
      nreq = nreq + 1;
    end
    if (done === 1'b1) ndone = ndone + 1;
    req_prev = req;
    x_prev   = {DADR, CADR, DLEN, DBIT};
  end

  task automatic step(input int c);
    repeat (c) @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic lvl, input string tag);
    int k = 0;
    while (req !== lvl && k < 50) begin step(1); k++; end
    chk(tag, {31'b0, req}, {31'b0, lvl});
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done !== 1'b1 && k < 50) begin step(1); k++; end
    chk(tag, {31'b0, done}, 32'd1);
  endtask

  task automatic wr(input logic d, input logic c, input logic t,
                    input logic [5:0] a, input logic l, input logic b);
    wr_dadr = d; wr_cadr = c; wr_ctrl = t;
    wdata_adr = a; wdata_dlen = l; wdata_dbit = b;
    step(1);
    wr_dadr = 0; wr_cadr = 0; wr_ctrl = 0;
  endtask

  initial begin
    HRESETn = 0; wr_dadr = 0; wr_cadr = 0; wr_ctrl = 0; wdata_adr = '0;
    wdata_dlen = 0; wdata_dbit = 0; err_clr = 0; ack_auto = 1; ack_man = 0;
    step(2);
    HRESETn = 1;
    for (int i = 0; i < 10; i++)
      chk("idle_after_reset", {18'b0, req, busy, pending, done, err, DADR, CADR, DLEN, DBIT}, 32'd0);

    // Single transfer: DADR + ctrl in one write cycle.
    b_req = nreq; b_done = ndone;
    wr(1, 0, 1, 6'b001101, 1, 1);
    chk("pend_after_wr", {31'b0, pending}, 32'd1);
    wait_req(1, "single_req_up");
    chk("single_payload", {18'b0, DADR, CADR, DLEN, DBIT}, {18'b0, 6'b001101, 6'b000000, 2'b11});
    wait_done("single_done");
    step(10);
    chk("single_nreq", nreq - b_req, 32'd1);
    chk("single_ndone", ndone - b_done, 32'd1);
    chk("single_pend_clr", {31'b0, pending}, 32'd0);
    chk("single_hold", {18'b0, DADR, CADR, DLEN, DBIT}, {18'b0, 6'b001101, 6'b000000, 2'b11});

    // Write in the launch cycle: old payload first, follow-up with new.
    b_req = nreq; b_done = ndone;
    wr(0, 1, 0, 6'b011111, 0, 0);
    wr(1, 0, 0, 6'b100001, 0, 0);
    chk("launch_req", {31'b0, req}, 32'd1);
    chk("launch_pend", {31'b0, pending}, 32'd1);
    chk("launch_old_payload", {18'b0, DADR, CADR, DLEN, DBIT}, {18'b0, 6'b001101, 6'b011111, 2'b11});
    wait_done("launch_done1");
    step(1);
    wait_done("launch_done2");
    step(10);
    chk("launch_nreq", nreq - b_req, 32'd2);
    chk("launch_ndone", ndone - b_done, 32'd2);
    chk("launch_new_payload", {18'b0, log_x[nreq-1]}, {18'b0, 6'b100001, 6'b011111, 2'b11});

    // Writes during REQ coalesce into one back-to-back follow-up.
    b_req = nreq; b_done = ndone;
    wr(0, 0, 1, 6'b000000, 1, 1);
    wait_req(1, "coal_req_up");
    wr(1, 0, 0, 6'b111111, 0, 0);
    wr(0, 1, 0, 6'b011000, 0, 0);
    wr(0, 0, 1, 6'b000000, 0, 0);
    chk("coal_busy", {31'b0, busy}, 32'd1);
    wait_done("coal_done1");
    chk("coal_first_payload", {18'b0, DADR, CADR, DLEN, DBIT}, {18'b0, 6'b100001, 6'b011111, 2'b11});
    step(1);
    chk("coal_b2b_req", {31'b0, req}, 32'd1);
    chk("coal_second_payload", {18'b0, DADR, CADR, DLEN, DBIT}, {18'b0, 6'b111111, 6'b011000, 2'b00});
    wait_done("coal_done2");
    step(10);
    chk("coal_nreq", nreq - b_req, 32'd2);
    chk("coal_ndone", ndone - b_done, 32'd2);

    // Timeout: ack held low.
    b_done = ndone;
    ack_auto = 0; ack_man = 0;
    wr(1, 0, 0, 6'b000111, 0, 0);
    wait_req(1, "to_req_up");
    n = 0;
    while (req === 1'b1 && n < 20) begin n++; step(1); end
    chk("to_req_cycles", n, 32'd7);
    chk("to_err", {31'b0, err}, 32'd1);
    chk("to_abort_busy", {31'b0, busy}, 32'd1);
    step(1);
    chk("to_idle", {30'b0, busy, pending}, 32'd1);
    step(1);
    chk("to_retry_req", {31'b0, req}, 32'd1);
    chk("to_retry_payload", {26'b0, DADR}, 32'b000111);
    chk("to_no_done", ndone - b_done, 32'd0);
    ack_auto = 1;
    wait_done("to_retry_done");
    chk("to_err_sticky", {31'b0, err}, 32'd1);
    err_clr = 1; step(1); err_clr = 0;
    chk("to_err_clr", {31'b0, err}, 32'd0);
    step(10);

    // Reset while in REL.
    wr(1, 0, 0, 6'b010101, 0, 0);
    wait_req(1, "rst_req_up");
    wait_req(0, "rst_rel");
    wr(1, 0, 0, 6'b110011, 0, 0);
    HRESETn = 0; step(1); HRESETn = 1;
    chk("rst_clear", {18'b0, req, busy, pending, done, err, DADR[4:0], CADR, DLEN, DBIT}, 32'd0);
    chk("rst_dadr", {26'b0, DADR}, 32'd0);
    b_req = nreq;
    ack_auto = 0; ack_man = 1;
    step(5);
    chk("rst_ack_ignored", {30'b0, req, busy}, 32'd0);
    chk("rst_no_req", nreq - b_req, 32'd0);
    ack_man = 0;
    step(2);
    chk("payload_stable", unstable, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
